// File: rtl/frame_pixel_fetch.sv
// frame_pixel_fetch: places camera pixels from a FWFT FIFO into a fixed
// window of the display raster, emitting a border colour outside it.
// Locks to camera frames using the sof tag bit (i_fifo_data[24]).
// Optional feature macro: FRAME_PIXEL_FETCH_STATS_EN builds the
// underflow / resync counters; otherwise both counter outputs read 0.
module frame_pixel_fetch #(
  parameter int          IMG_W           = 1280,
  parameter int          IMG_H           = 720,
  parameter int          X_OFF           = 0,
  parameter int          Y_OFF           = 152,
  parameter logic [23:0] BORDER_COLOR    = 24'h000000,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic               i_pixel_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_hve,
  input  logic signed [12:0] i_x,
  input  logic signed [12:0] i_y,
  input  logic [24:0]        i_fifo_data,
  input  logic               i_fifo_empty,
  output logic               o_fifo_rd,
  output logic [2:0]         o_hve,
  output logic [23:0]        o_rgb,
  output logic               o_locked,
  output logic [15:0]        o_underflow_cnt,
  output logic [15:0]        o_resync_cnt
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Window bounds as 14-bit signed values so negative blanking coordinates
  // and the exclusive upper edge never wrap.
  localparam logic signed [13:0] X_LO = 14'(X_OFF);
  localparam logic signed [13:0] X_HI = 14'(X_OFF + IMG_W);
  localparam logic signed [13:0] Y_LO = 14'(Y_OFF);
  localparam logic signed [13:0] Y_HI = 14'(Y_OFF + IMG_H);

  logic signed [13:0] x_ext;
  logic signed [13:0] y_ext;
  logic               in_win;
  logic               win_start;
  logic               head_sof;

  logic [1:0]  state_q, state_d;
  logic        fifo_rd;
  logic        show_head;
  logic [2:0]  hve_q;
  logic [23:0] rgb_q, rgb_d;
  logic        locked_q;

  assign x_ext     = {i_x[12], i_x};
  assign y_ext     = {i_y[12], i_y};
  assign in_win    = i_hve[2] && (x_ext >= X_LO) && (x_ext < X_HI)
                     && (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign win_start = in_win && (x_ext == X_LO) && (y_ext == Y_LO);
  assign head_sof  = !i_fifo_empty && i_fifo_data[24];

  // Frame-lock state machine: decides the pop and whether the head is shown.
  always_comb begin
    state_d   = state_q;
    fifo_rd   = 1'b0;
    show_head = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // Discarded words are never displayed.
        fifo_rd = !i_fifo_empty && !head_sof;
        if (head_sof) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_WAIT: begin
        if (win_start && head_sof) begin
          fifo_rd   = 1'b1;
          show_head = 1'b1;
          state_d   = ST_LOCKED;
        end else if (win_start) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_LOCKED: begin
        if (!in_win) begin
          state_d = ST_LOCKED;
        end else if (i_fifo_empty) begin
          state_d = ST_SEARCH;            // underflow
        end else if (win_start && !head_sof) begin
          state_d = ST_SEARCH;            // frame start without sof
        end else if (!win_start && head_sof) begin
          state_d = ST_WAIT;              // next frame arrived early
        end else begin
          fifo_rd   = 1'b1;
          show_head = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  assign o_fifo_rd = fifo_rd && !i_reset;

  // Pixel select for the registered output stage.
  always_comb begin
    rgb_d = 24'h000000;
    if (!i_hve[2]) begin
      rgb_d = 24'h000000;
    end else if (!in_win) begin
      rgb_d = BORDER_COLOR;
    end else if (show_head) begin
      rgb_d = i_fifo_data[23:0];
    end else begin
      rgb_d = UNDERFLOW_COLOR;
    end
  end

  // State and one-cycle output pipeline.
  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      state_q  <= ST_SEARCH;
      hve_q    <= 3'b000;
      rgb_q    <= 24'h000000;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hve_q    <= i_hve;
      rgb_q    <= rgb_d;
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  assign o_hve    = hve_q;
  assign o_rgb    = rgb_q;
  assign o_locked = locked_q;

`ifdef FRAME_PIXEL_FETCH_STATS_EN
  logic        uf_evt;
  logic        resync_evt;
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] rs_cnt_q, rs_cnt_d;

  // Underflow and misalignment in one cycle give one of each event.
  assign uf_evt     = (state_q == ST_LOCKED) && in_win && i_fifo_empty;
  assign resync_evt = (state_d == ST_SEARCH) && (state_q != ST_SEARCH);

  // Saturating event counters.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    rs_cnt_d = rs_cnt_q;
    if (uf_evt && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end else begin
      uf_cnt_d = uf_cnt_q;
    end
    if (resync_evt && (rs_cnt_q != 16'hFFFF)) begin
      rs_cnt_d = rs_cnt_q + 16'd1;
    end else begin
      rs_cnt_d = rs_cnt_q;
    end
  end

  // Counter registers; reset entry to SEARCH is not counted.
  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      uf_cnt_q <= 16'h0000;
      rs_cnt_q <= 16'h0000;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      rs_cnt_q <= rs_cnt_d;
    end
  end

  assign o_underflow_cnt = uf_cnt_q;
  assign o_resync_cnt    = rs_cnt_q;
`else
  assign o_underflow_cnt = 16'h0000;
  assign o_resync_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_pixel_fetch.sv
// Directed bench for frame_pixel_fetch on a 10x5 raster (8x4 active) with a
// 4x2 window at (2,1). The FIFO is a bench queue presented as FWFT.
module tb_frame_pixel_fetch;

`ifdef FRAME_PIXEL_FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [2:0]         hve;
  logic signed [12:0] x;
  logic signed [12:0] y;
  logic [24:0]        fdata;
  logic               fempty;
  logic               o_fifo_rd;
  logic [2:0]         o_hve;
  logic [23:0]        o_rgb;
  logic               o_locked;
  logic [15:0]        o_underflow_cnt;
  logic [15:0]        o_resync_cnt;

  logic [24:0] fifo_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] win_seen [8];
  int          border_bad;
  int          hve_bad;
  int          pops_pre;
  logic        locked_ws;
  logic        rd;

  frame_pixel_fetch #(
    .IMG_W(4), .IMG_H(2), .X_OFF(2), .Y_OFF(1)
  ) u_dut (
    .i_pixel_clk    (clk),
    .i_reset        (rst),
    .i_hve          (hve),
    .i_x            (x),
    .i_y            (y),
    .i_fifo_data    (fdata),
    .i_fifo_empty   (fempty),
    .o_fifo_rd      (o_fifo_rd),
    .o_hve          (o_hve),
    .o_rgb          (o_rgb),
    .o_locked       (o_locked),
    .o_underflow_cnt(o_underflow_cnt),
    .o_resync_cnt   (o_resync_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fempty = (fifo_q.size() == 0);
    fdata  = fempty ? 25'h0 : fifo_q[0];
  endtask

  // One pixel: drive, sample the pop strobe, clock, apply the pop, settle.
  task automatic pix(input int xx, input int yy, input logic de, output logic rd_seen);
    hve = {de, 1'b0, (xx == 8)};
    x   = 13'(xx);
    y   = 13'(yy);
    drive_fifo();
    #1;
    rd_seen = o_fifo_rd;
    @(posedge clk);
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic push_frame(input logic [23:0] base, input int n, input int sof_at2);
    for (int k = 0; k < n; k++)
      fifo_q.push_back({(k == 0) || (k == sof_at2), base + 24'(k)});
  endtask

  task automatic run_frame();
    logic de;
    logic started;
    int   k;
    border_bad = 0;
    hve_bad    = 0;
    pops_pre   = 0;
    started    = 1'b0;
    for (int yy = 0; yy < 5; yy++) begin
      for (int xx = 0; xx < 10; xx++) begin
        logic r;
        de = (xx < 8) && (yy < 4);
        pix(xx, yy, de, r);
        if (o_hve != {de, 1'b0, (xx == 8)}) hve_bad++;
        if (de && xx >= 2 && xx <= 5 && yy >= 1 && yy <= 2) begin
          k = (yy - 1) * 4 + (xx - 2);
          win_seen[k] = o_rgb;
          if (k == 0) begin
            locked_ws = o_locked;
            started   = 1'b1;
          end
        end else begin
          if (o_rgb != 24'h000000) border_bad++;
          if (!started && r) pops_pre++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hve = 3'b000; x = 13'sd0; y = 13'sd0;
    drive_fifo();

    // Reset state
    pix(0, 0, 1'b0, rd);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_hve", {29'd0, o_hve}, 32'd0);
    check("rst_rgb", {8'd0, o_rgb}, 32'd0);
    check("rst_locked", {31'd0, o_locked}, 32'd0);
    check("rst_ufcnt", {16'd0, o_underflow_cnt}, 32'd0);
    check("rst_rscnt", {16'd0, o_resync_cnt}, 32'd0);
    rst = 1'b0;

    // Lock on a clean frame
    push_frame(24'hA00000, 8, -1);
    run_frame();
    for (int k = 0; k < 8; k++)
      check($sformatf("s1_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hA00000 + 24'(k)});
    check("s1_border", border_bad, 0);
    check("s1_hve", hve_bad, 0);
    check("s1_locked_ws", {31'd0, locked_ws}, 32'd1);
    check("s1_pops_pre", pops_pre, 0);

    // Garbage before sof after a fresh reset
    rst = 1'b1;
    pix(0, 4, 1'b0, rd);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) fifo_q.push_back({1'b0, 24'hEE0000 + 24'(k)});
    push_frame(24'hB00000, 8, -1);
    run_frame();
    check("s2_pops_pre", pops_pre, 3);
    for (int k = 0; k < 8; k++)
      check($sformatf("s2_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hB00000 + 24'(k)});
    check("s2_rscnt", {16'd0, o_resync_cnt}, 32'd0);
    check("s2_locked", {31'd0, o_locked}, 32'd1);

    // Underflow mid-frame: 5 of 8 words
    push_frame(24'hC00000, 5, -1);
    run_frame();
    for (int k = 0; k < 5; k++)
      check($sformatf("s3_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hC00000 + 24'(k)});
    for (int k = 5; k < 8; k++)
      check($sformatf("s3_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hFF00FF});
    check("s3_ufcnt", {16'd0, o_underflow_cnt}, STATS ? 32'd1 : 32'd0);
    check("s3_rscnt", {16'd0, o_resync_cnt}, STATS ? 32'd1 : 32'd0);
    check("s3_locked", {31'd0, o_locked}, 32'd0);

    // Relock on the following frame
    push_frame(24'hD00000, 8, -1);
    run_frame();
    check("s3r_win0", {8'd0, win_seen[0]}, {8'd0, 24'hD00000});
    check("s3r_win7", {8'd0, win_seen[7]}, {8'd0, 24'hD00007});
    check("s3r_locked", {31'd0, o_locked}, 32'd1);

    // Early sof at position 4
    push_frame(24'hE00000, 8, 4);
    run_frame();
    for (int k = 0; k < 4; k++)
      check($sformatf("s4_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hE00000 + 24'(k)});
    for (int k = 4; k < 8; k++)
      check($sformatf("s4_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hFF00FF});
    check("s4_locked", {31'd0, o_locked}, 32'd0);
    check("s4_rscnt", {16'd0, o_resync_cnt}, STATS ? 32'd1 : 32'd0);
    for (int k = 8; k < 12; k++) fifo_q.push_back({1'b0, 24'hE00000 + 24'(k)});
    run_frame();
    for (int k = 0; k < 8; k++)
      check($sformatf("s4n_win%0d", k), {8'd0, win_seen[k]}, {8'd0, 24'hE00004 + 24'(k)});
    check("s4n_locked", {31'd0, o_locked}, 32'd1);

    // Reset mid-frame while locked at x=3
    push_frame(24'hF00000, 8, -1);
    for (int xx = 0; xx < 10; xx++) pix(xx, 0, xx < 8, rd);
    for (int xx = 0; xx < 3; xx++) pix(xx, 1, 1'b1, rd);
    check("s5_locked_pre", {31'd0, o_locked}, 32'd1);
    rst = 1'b1;
    pix(3, 1, 1'b1, rd);
    check("s5_rd_in_rst", {31'd0, rd}, 32'd0);
    check("s5_hve", {29'd0, o_hve}, 32'd0);
    check("s5_rgb", {8'd0, o_rgb}, 32'd0);
    check("s5_locked", {31'd0, o_locked}, 32'd0);
    check("s5_ufcnt", {16'd0, o_underflow_cnt}, 32'd0);
    check("s5_rscnt", {16'd0, o_resync_cnt}, 32'd0);
    rst = 1'b0;
    pix(6, 1, 1'b1, rd);
    check("s5_discard", {31'd0, rd}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
